// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
// Shared definitions for the ALU issue stage: instruction field positions,
// the opcode-to-alusignals bit map, the issue FSM state type and the
// one-hot ALU control decode helper.
package alu_issue_pkg;

    // Instruction word layout
    localparam int INSTR_W      = 16;
    localparam int OPC_MSB      = 15;
    localparam int OPC_LSB      = 12;
    localparam int IMM_FLAG_BIT = 11;
    localparam int IMM_MSB      = 4;
    localparam int IMM_LSB      = 0;
    localparam int ALU_W        = 12;

    // alusignals bit index for each ALU operation (equal to its opcode)
    localparam int ALU_ADD_BIT = 0;
    localparam int ALU_LD_BIT  = 1;
    localparam int ALU_ST_BIT  = 2;
    localparam int ALU_SUB_BIT = 3;
    localparam int ALU_MUL_BIT = 4;
    localparam int ALU_CMP_BIT = 5;
    localparam int ALU_DIV_BIT = 6;
    localparam int ALU_OR_BIT  = 7;
    localparam int ALU_AND_BIT = 8;
    localparam int ALU_NOT_BIT = 9;
    localparam int ALU_LSL_BIT = 10;
    localparam int ALU_LSR_BIT = 11;

    localparam logic [3:0] OPC_MUL  = 4'(ALU_MUL_BIT);
    // Highest opcode that maps to an ALU operation; above it is discarded
    localparam logic [3:0] OPC_LAST = 4'(ALU_LSR_BIT);

    typedef enum logic [0:0] {
        ST_ISSUE    = 1'b0,
        ST_MUL_HOLD = 1'b1
    } state_e;

    // One-hot ALU control for an opcode; zero for unused opcodes
    function automatic logic [ALU_W-1:0] alu_decode(input logic [3:0] opc);
        logic [ALU_W-1:0] sig;
        if (opc <= OPC_LAST) begin
            sig = 12'd1 << opc;
        end else begin
            sig = 12'd0;
        end
        return sig;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// issue_fifo
// Circular buffer of DEPTH entries with wrap-around pointers and an
// occupancy count. Push and pop are qualified by the parent; flush_i
// clears the pointers and count synchronously.
// Ports: clk, rst_n (async active-low), flush_i, push_i, pop_i,
//        wdata_i (entry in), rdata_o (head entry), count_o (occupancy).
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, count and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue
// Issue stage in front of an ALU. Instructions with their operands are
// queued in issue_fifo; each cycle in ISSUE the head is popped and decoded
// into registered ALU controls. A mul keeps the ALU busy, so the FSM parks
// in MUL_HOLD for MUL_CYCLES-1 cycles without popping.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_instr/in_op1/
//        in_op2 (upstream handshake); flush (sync discard); out_valid,
//        alusignals, op1, op2, immx, isimmediate, instr (ALU side);
//        count (buffer occupancy).
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int MUL_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            in_instr,
    input  logic [15:0]            in_op1,
    input  logic [15:0]            in_op2,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [11:0]            alusignals,
    output logic [15:0]            op1,
    output logic [15:0]            op2,
    output logic [4:0]             immx,
    output logic                   isimmediate,
    output logic [15:0]            instr,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam bit HOLD_EN = (MUL_CYCLES > 1);

    state_e        state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic          out_valid_q, out_valid_d;
    logic [11:0]   alu_q, alu_d;
    logic [15:0]   op1_q, op1_d, op2_q, op2_d, instr_q, instr_d;
    logic [4:0]    immx_q, immx_d;
    logic          isimm_q, isimm_d;

    logic [CW-1:0] fifo_count_s;
    logic [47:0]   head_s;
    logic [15:0]   h_instr_s, h_op1_s, h_op2_s;
    logic [3:0]    h_opc_s;
    logic          push_s, pop_s;

    // in_ready depends on registered occupancy only, never on a same-cycle pop
    assign in_ready = (fifo_count_s < CW'(DEPTH));
    assign push_s   = in_valid && in_ready && !flush;
    assign pop_s    = (state_q == ST_ISSUE) && (fifo_count_s != CW'(0)) && !flush;

    assign {h_instr_s, h_op1_s, h_op2_s} = head_s;
    assign h_opc_s = h_instr_s[OPC_MSB:OPC_LSB];

    issue_fifo #(
        .DEPTH(DEPTH),
        .W    (48)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ({in_instr, in_op1, in_op2}),
        .rdata_o (head_s),
        .count_o (fifo_count_s)
    );

    // FSM next state and decode of the popped head into the output registers
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_valid_d = 1'b0;
        alu_d       = 12'd0;
        op1_d       = op1_q;
        op2_d       = op2_q;
        immx_d      = immx_q;
        isimm_d     = isimm_q;
        instr_d     = instr_q;
        if (flush) begin
            state_d = ST_ISSUE;
            hold_d  = 8'd0;
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    if (pop_s && (h_opc_s <= OPC_LAST)) begin
                        out_valid_d = 1'b1;
                        alu_d       = alu_decode(h_opc_s);
                        op1_d       = h_op1_s;
                        op2_d       = h_op2_s;
                        immx_d      = h_instr_s[IMM_MSB:IMM_LSB];
                        isimm_d     = h_instr_s[IMM_FLAG_BIT];
                        instr_d     = h_instr_s;
                        if (HOLD_EN && (h_opc_s == OPC_MUL)) begin
                            state_d = ST_MUL_HOLD;
                            hold_d  = 8'(MUL_CYCLES - 2);
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        // empty buffer, or opcode 12..15 popped and dropped
                        state_d = ST_ISSUE;
                    end
                end
                ST_MUL_HOLD: begin
                    if (hold_q == 8'd0) begin
                        state_d = ST_ISSUE;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_ISSUE;
                    hold_d  = 8'd0;
                end
            endcase
        end
    end

    // FSM and ALU-side output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ISSUE;
            hold_q      <= 8'd0;
            out_valid_q <= 1'b0;
            alu_q       <= 12'd0;
            op1_q       <= 16'd0;
            op2_q       <= 16'd0;
            immx_q      <= 5'd0;
            isimm_q     <= 1'b0;
            instr_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            alu_q       <= alu_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            immx_q      <= immx_d;
            isimm_q     <= isimm_d;
            instr_q     <= instr_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alusignals  = alu_q;
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign immx        = immx_q;
    assign isimmediate = isimm_q;
    assign instr       = instr_q;
    assign count       = fifo_count_s;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the issue-buffer entry count (power of two, 2..8).
REQ-002 The block SHALL have parameter MUL_CYCLES, default 2, the number of cycles the ALU is occupied by an ismul operation.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream offers an instruction.
REQ-006 in_ready  output  1  buffer can accept; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-007 in_instr  input  16  instruction: [15:12] opcode, [11] immediate flag, [4:0] immediate.
REQ-008 in_op1, in_op2  input  16 each  operand values captured with in_instr.
REQ-009 flush  input  1  synchronous discard of all buffered and in-flight work.
REQ-010 out_valid  output  1  ALU-side outputs carry an issued operation this cycle.
REQ-011 alusignals  output  12  one-hot ALU control: bit 0 add, 3 sub, 4 mul, 5 cmp, 7 or, 8 and, 10 lsl, 11 lsr; bits 1, 2, 6, 9 ld, st, div, not.
REQ-012 op1, op2  output  16 each  operands to the ALU.
REQ-013 immx  output  5  immediate to the ALU.
REQ-014 isimmediate  output  1  ALU selects immx instead of op2.
REQ-015 instr  output  16  issued instruction word, forwarded unmodified.
REQ-016 count  output  log2(DEPTH)+1  current buffer occupancy.

Function
REQ-017 The buffer SHALL be a FIFO of DEPTH entries {instr, op1, op2} with wrap-around read/write pointers.
REQ-018 in_ready SHALL equal (count < DEPTH), computed from registered count only; a pop in the same cycle SHALL NOT raise in_ready when the buffer is full.
REQ-019 The FSM SHALL have states ISSUE and MUL_HOLD; reset state ISSUE.
REQ-020 In ISSUE with count > 0, the head SHALL be popped each cycle and decoded into the output registers at that edge.
REQ-021 Decode: opcode 0..11 SHALL set alusignals = 1 << opcode, out_valid = 1; isimmediate = instr[11]; immx = instr[4:0].
REQ-022 Opcodes 12..15 SHALL be popped and discarded: out_valid = 0, alusignals = 0.
REQ-023 Latency: an instruction accepted at edge t into an empty buffer in ISSUE SHALL appear on the outputs after edge t+1.
REQ-024 When opcode 4 (mul) issues, the FSM SHALL enter MUL_HOLD for MUL_CYCLES-1 cycles with no pop, out_valid = 0, alusignals = 0, then return to ISSUE.
REQ-025 Whenever out_valid = 0, alusignals SHALL be 0; op1, op2, immx, isimmediate and instr SHALL hold their last values.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; when the buffer is empty, a push SHALL NOT bypass to the outputs in the same edge.
REQ-027 flush SHALL, at the next edge, empty the FIFO, zero count, clear out_valid and alusignals, and force ISSUE; flush has priority over a simultaneous push, which is dropped.
REQ-028 Issue order SHALL equal acceptance order.

Reset
REQ-029 While rst_n = 0: pointers, count, out_valid, alusignals, op1, op2, immx, isimmediate and instr SHALL be 0, and the FSM SHALL be in ISSUE; in_ready SHALL read 1.
REQ-030 Reset asserted mid-operation SHALL discard all entries, including a pending MUL_HOLD, immediately and without waiting for clk.

Structure
REQ-031 A shared package SHALL hold the opcode-to-alusignals bit constants, the field positions of instr, and the FSM state typedef.
REQ-032 The FIFO storage and pointers SHALL be a sub-module named issue_fifo; decode and the FSM stay in alu_issue.

Verification
REQ-033 Push add (in_instr 16'h0000, op1 16'h0005, op2 16'h0003) into an empty buffer -> one edge later out_valid = 1, alusignals = 12'h001, op1 = 5, op2 = 3.
REQ-034 Push mul (16'h4000) then add back-to-back -> mul issues with alusignals = 12'h010, followed by a one-cycle bubble (out_valid = 0), then add issues.
REQ-035 Push immediate add 16'h0802 with op1 16'h0004 -> isimmediate = 1, immx = 5'b00010, alusignals = 12'h001.
REQ-036 Push 5 instructions with DEPTH = 4 while the FSM is held in MUL_HOLD -> in_ready = 0 at count = 4, the fifth instruction is accepted only after a pop, and order is preserved.
REQ-037 Push opcode 13 (16'hD000) between two adds -> no issue for it; the adds issue in order with a single out_valid = 0 gap.
REQ-038 Assert flush, then separately rst_n = 0, with 3 entries buffered and in MUL_HOLD -> count = 0, out_valid = 0, in_ready = 1, and no further issues.
